clock_control: RTL and testbench
================================

# clock_control

Front-end controller that drives the `manual_en`, `adv_clk` and `halt` inputs of `clock_module`. It runs off the free-running oscillator. It conditions three raw push-buttons (mode, step, resume) through synchronizers, debouncers and press detectors. It also latches a halt request from the control unit into a three-state run/manual/halted FSM. Every output is registered and glitch-free, so `clock_module` only ever sees clean, oscillator-aligned control levels and single-cycle step pulses.

## Interface
- `DB_CYCLES`, 15: consecutive stable samples needed before a debounced button changes state (≥1).
- `DB_W`, 4: debounce counter width; must satisfy 2^DB_W > DB_CYCLES.

- `clk_generator`  in  1  free-running oscillator; all logic on its rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `mode_btn`  in  1  raw asynchronous active-high button; toggles run/manual.
- `step_btn`  in  1  raw asynchronous active-high button; single-step in manual mode.
- `resume_btn`  in  1  raw asynchronous active-high button; leaves HALTED.
- `hlt_req`  in  1  level from control unit, synchronous to `clk_generator`; rising edge requests halt.
- `manual_en`  out  1  to `clock_module`; 1 = manual stepping.
- `adv_clk`  out  1  to `clock_module`; one-cycle step pulse.
- `halt`  out  1  to `clock_module`; 1 = clock stopped.
- `state`  out  2  debug: 00 RUN, 01 MANUAL, 10 HALTED.

## Operation
- **Button path.** Each button uses a 2-FF synchronizer (reset 0), then a debouncer.
  - The debouncer holds `db` (reset 0) and counter `cnt` (reset 0).
  - When the synced value ≠ `db`, `cnt` increments. When it reaches DB_CYCLES, `db` flips and `cnt` clears.
  - Any cycle where synced value = `db` clears `cnt`. Bounces shorter than DB_CYCLES are rejected.
  - A press pulse is registered: `press = db & ~db_d`, one cycle wide, on the rising edge of `db` only. Release produces no pulse.
- **Halt edge.** `hlt_rise = hlt_req & ~hlt_d`, where `hlt_d` resets to 0. A level held high across reset release therefore halts immediately.
- **FSM, RUN.** Outputs `manual_en`=0, `halt`=0.
  - `hlt_rise` → HALTED, with saved_mode=0.
  - Otherwise, mode press → MANUAL.
  - Step presses are ignored.
- **FSM, MANUAL.** Output `manual_en`=1.
  - `hlt_rise` → HALTED, with saved_mode=1.
  - Otherwise, a step press drives `adv_clk`=1 for exactly one cycle.
  - A mode press → RUN.
  - Step and mode pressed in the same cycle: the pulse is still issued and the state moves to RUN.
- **FSM, HALTED.** Output `halt`=1; `manual_en` = saved_mode.
  - Resume press → RUN if saved_mode=0, MANUAL if saved_mode=1.
  - Mode and step presses are ignored; `adv_clk` stays 0.
  - A fresh `hlt_rise` while halted has no effect.
- **Priority within a cycle:** `hlt_rise` > resume > mode > step. A `hlt_rise` coincident with a step press in MANUAL suppresses the pulse.
- **Reset** (`rst_n`=0 at a rising edge) applies regardless of state, including mid-debounce or mid-pulse.
  - Reset values: state RUN, saved_mode 0, `manual_en` 0, `adv_clk` 0, `halt` 0, all `db`/`cnt`/sync/edge registers 0.
- State encoding 11 is unreachable and recovers to RUN on the next edge.

## Timing
- **Button latency.** Raw high is first sampled at edge 0.
  - Sync output is high after edge 1.
  - `db` flips at edge 1+DB_CYCLES.
  - The press pulse registers at edge 2+DB_CYCLES.
  - The FSM/output change registers at edge 3+DB_CYCLES. That is 18 cycles at the default.
- **Halt latency.** `halt` rises on the same edge that first samples `hlt_req` high, so it is visible one cycle after `hlt_req` is presented.
- `adv_clk` is high for exactly one `clk_generator` period per press, and never for two consecutive cycles.
- Holding a button produces one pulse. A further pulse requires a release stable for DB_CYCLES followed by a new press.
- `manual_en` and `halt` change only on `clk_generator` rising edges, with no combinational path from any input.

## Test plan
Directed scenarios run with DB_CYCLES=4.

- **Reset.** Hold `rst_n`=0 for 3 cycles with all buttons bouncing → `manual_en`=0, `adv_clk`=0, `halt`=0, `state`=00 throughout and on the first cycle after release.
- **Debounce.** Mode pulses of 1, 2 and 3 cycles separated by low gaps → no state change. A 5-cycle-stable press → `state`=01 and `manual_en`=1 exactly 7 edges after the first high sample.
- **Stepping.** In MANUAL, hold a step press for 20 cycles → exactly one `adv_clk` cycle. Release for 6 cycles, then press again → a second single pulse.
- **Halt and resume.** In MANUAL, assert `hlt_req` → `halt`=1 the next cycle and `manual_en` stays 1. Step presses give no `adv_clk`. A resume press → `state`=01 and `halt`=0. Repeat from RUN → resume returns `state`=00.
- **Simultaneous events.** In MANUAL, step and mode debounced on the same cycle → one `adv_clk` pulse and `state`=00. Step press coincident with `hlt_rise` → no pulse and `state`=10.
- **Reset mid-operation.** Assert `rst_n`=0 during an `adv_clk` pulse and during HALTED → all outputs 0 and `state`=00 on the next edge. With `hlt_req` held high through reset release → `halt`=1 one cycle after release.

Source files
------------

// File: rtl/clock_control.sv
// Button conditioning and run/manual/halted control for clock_module.
// All outputs are registered on clk_generator; no input reaches an output combinationally.
module clock_control #(
    parameter int DB_CYCLES = 15,
    parameter int DB_W      = 4
) (
    input  logic       clk_generator,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       step_btn,
    input  logic       resume_btn,
    input  logic       hlt_req,
    output logic       manual_en,
    output logic       adv_clk,
    output logic       halt,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        MANUAL = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam int BTN_MODE   = 0;
    localparam int BTN_STEP   = 1;
    localparam int BTN_RESUME = 2;
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      db;
    logic [2:0]      db_d;
    logic [2:0]      press;
    logic [DB_W-1:0] cnt [3];
    logic            hlt_d;
    logic            hlt_rise;
    logic            saved_mode;
    state_t          st;

    assign raw      = {resume_btn, step_btn, mode_btn};
    assign hlt_rise = hlt_req & ~hlt_d;
    assign state    = st;

    // Synchronizer, debouncer and press detector for all three buttons.
    always_ff @(posedge clk_generator) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            press <= db & ~db_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priority: hlt_rise > resume > mode > step.
    always_ff @(posedge clk_generator) begin
        if (!rst_n) begin
            st         <= RUN;
            saved_mode <= 1'b0;
            manual_en  <= 1'b0;
            adv_clk    <= 1'b0;
            halt       <= 1'b0;
            hlt_d      <= 1'b0;
        end else begin
            hlt_d   <= hlt_req;
            adv_clk <= 1'b0;
            case (st)
                RUN: begin
                    if (hlt_rise) begin
                        st         <= HALTED;
                        saved_mode <= 1'b0;
                        halt       <= 1'b1;
                        manual_en  <= 1'b0;
                    end else if (press[BTN_MODE]) begin
                        st        <= MANUAL;
                        manual_en <= 1'b1;
                    end
                end
                MANUAL: begin
                    if (hlt_rise) begin
                        st         <= HALTED;
                        saved_mode <= 1'b1;
                        halt       <= 1'b1;
                        manual_en  <= 1'b1;
                    end else begin
                        adv_clk <= press[BTN_STEP];
                        if (press[BTN_MODE]) begin
                            st        <= RUN;
                            manual_en <= 1'b0;
                        end
                    end
                end
                HALTED: begin
                    if (press[BTN_RESUME]) begin
                        st        <= saved_mode ? MANUAL : RUN;
                        halt      <= 1'b0;
                        manual_en <= saved_mode;
                    end
                end
                default: begin
                    st        <= RUN;
                    manual_en <= 1'b0;
                    halt      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clock_control.sv
// Bench for clock_control: directed scenarios plus a randomized run against a
// behavioural model built from sample windows and mode rules.
module tb_clock_control;
    localparam int DB  = 4;
    localparam int DBW = 3;
    localparam logic [2:0] B_MODE = 3'b001;
    localparam logic [2:0] B_STEP = 3'b010;
    localparam logic [2:0] B_RES  = 3'b100;

    logic       clk_generator = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       step_btn = 1'b0;
    logic       resume_btn = 1'b0;
    logic       hlt_req = 1'b0;
    logic       manual_en;
    logic       adv_clk;
    logic       halt;
    logic [1:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    // model: 0 = run, 1 = manual, 2 = halted
    logic [2:0]    m_s1 = '0, m_s2 = '0, m_db = '0, m_dbd = '0, m_press = '0;
    logic [DB-1:0] m_win [3];
    int            m_fill [3];
    logic          m_hltd = 1'b0, m_saved = 1'b0, m_adv = 1'b0;
    int            m_mode = 0;

    int   dut_adv_cnt = 0;
    int   mdl_adv_cnt = 0;
    int   adv_consec = 0;
    logic prev_adv = 1'b0;

    always #5 clk_generator = ~clk_generator;

    clock_control #(.DB_CYCLES(DB), .DB_W(DBW)) dut (
        .clk_generator(clk_generator),
        .rst_n(rst_n),
        .mode_btn(mode_btn),
        .step_btn(step_btn),
        .resume_btn(resume_btn),
        .hlt_req(hlt_req),
        .manual_en(manual_en),
        .adv_clk(adv_clk),
        .halt(halt),
        .state(state)
    );

    function automatic logic [1:0] exp_state();
        return m_mode[1:0];
    endfunction

    function automatic logic exp_manual();
        return (m_mode == 1) || (m_mode == 2 && m_saved);
    endfunction

    function automatic logic exp_halt();
        return (m_mode == 2);
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_dbd = '0; m_press = '0;
        m_hltd = 1'b0; m_saved = 1'b0; m_adv = 1'b0; m_mode = 0;
        for (int i = 0; i < 3; i++) begin
            m_win[i] = '0;
            m_fill[i] = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model over the rising edge, settle at the falling edge.
    task automatic tick(input logic r, input logic [2:0] b, input logic h);
        logic rise;
        logic pnew;
        rst_n = r; mode_btn = b[0]; step_btn = b[1]; resume_btn = b[2]; hlt_req = h;
        @(posedge clk_generator);
        if (!r) begin
            model_reset();
        end else begin
            rise = h & ~m_hltd;
            m_adv = 1'b0;
            if (m_mode == 2) begin
                if (m_press[2]) m_mode = m_saved ? 1 : 0;
            end else if (rise) begin
                m_saved = (m_mode == 1);
                m_mode = 2;
            end else if (m_mode == 1) begin
                m_adv = m_press[1];
                if (m_press[0]) m_mode = 0;
            end else if (m_press[0]) begin
                m_mode = 1;
            end
            m_hltd = h;
            for (int i = 0; i < 3; i++) begin
                pnew = m_db[i] & ~m_dbd[i];
                m_dbd[i] = m_db[i];
                m_win[i] = {m_win[i][DB-2:0], m_s2[i]};
                if (m_fill[i] < DB) m_fill[i]++;
                if (m_fill[i] == DB && m_win[i] == {DB{~m_db[i]}}) begin
                    m_db[i] = ~m_db[i];
                    m_fill[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = b[i];
                m_press[i] = pnew;
            end
        end
        @(negedge clk_generator);
        if (adv_clk === 1'b1) dut_adv_cnt++;
        if (adv_clk === 1'b1 && prev_adv === 1'b1) adv_consec++;
        prev_adv = adv_clk;
        if (m_adv) mdl_adv_cnt++;
    endtask

    task automatic hold(input logic [2:0] b, input logic h, input int n);
        repeat (n) tick(1'b1, b, h);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            tests_run++;
            if ({manual_en, adv_clk, halt, state} !== 5'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: outputs=%b required=00000", i, {manual_en, adv_clk, halt, state});
            end
        end
        tick(1'b1, 3'b000, 1'b0);
        tests_run++;
        if ({manual_en, adv_clk, halt, state} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_release: outputs=%b required=00000", {manual_en, adv_clk, halt, state});
        end
    endtask

    task automatic test_debounce();
        for (int w = 1; w <= 3; w++) begin
            hold(B_MODE, 1'b0, w);
            hold(3'b000, 1'b0, 8);
            tests_run++;
            if (state !== 2'b00 || manual_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL debounce_reject_%0d: state=%b manual_en=%b required 00/0", w, state, manual_en);
            end
        end
        hold(B_MODE, 1'b0, 5);
        hold(3'b000, 1'b0, 2);
        tests_run++;
        if (state !== 2'b00) begin
            tests_failed++;
            $display("FAIL debounce_early: state=%b required=00 after 7 edges", state);
        end
        tick(1'b1, 3'b000, 1'b0);
        tests_run++;
        if (state !== 2'b01 || manual_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL debounce_accept: state=%b manual_en=%b required 01/1", state, manual_en);
        end
        hold(3'b000, 1'b0, 8);
    endtask

    task automatic test_stepping();
        dut_adv_cnt = 0;
        adv_consec = 0;
        hold(B_STEP, 1'b0, 20);
        tests_run++;
        if (dut_adv_cnt !== 1) begin
            tests_failed++;
            $display("FAIL step_hold_single: pulses=%0d required=1", dut_adv_cnt);
        end
        hold(3'b000, 1'b0, 6);
        hold(B_STEP, 1'b0, 20);
        hold(3'b000, 1'b0, 8);
        tests_run++;
        if (dut_adv_cnt !== 2 || adv_consec !== 0 || state !== 2'b01) begin
            tests_failed++;
            $display("FAIL step_second_press: pulses=%0d consec=%0d state=%b required 2/0/01", dut_adv_cnt, adv_consec, state);
        end
    endtask

    task automatic test_halt_resume();
        tick(1'b1, 3'b000, 1'b1);
        tests_run++;
        if (halt !== 1'b1 || manual_en !== 1'b1 || state !== 2'b10) begin
            tests_failed++;
            $display("FAIL halt_from_manual: halt=%b manual_en=%b state=%b required 1/1/10", halt, manual_en, state);
        end
        dut_adv_cnt = 0;
        hold(B_STEP, 1'b1, 8);
        hold(3'b000, 1'b1, 8);
        tests_run++;
        if (dut_adv_cnt !== 0) begin
            tests_failed++;
            $display("FAIL halted_step_ignored: pulses=%0d required=0", dut_adv_cnt);
        end
        tick(1'b1, 3'b000, 1'b0);
        tick(1'b1, 3'b000, 1'b1);
        tests_run++;
        if (state !== 2'b10 || manual_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL halted_fresh_rise: state=%b manual_en=%b required 10/1", state, manual_en);
        end
        hold(B_RES, 1'b1, 8);
        hold(3'b000, 1'b1, 8);
        tests_run++;
        if (state !== 2'b01 || halt !== 1'b0 || manual_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL resume_to_manual: state=%b halt=%b manual_en=%b required 01/0/1", state, halt, manual_en);
        end
        hold(3'b000, 1'b0, 2);
        hold(B_MODE, 1'b0, 8);
        hold(3'b000, 1'b0, 8);
        tick(1'b1, 3'b000, 1'b1);
        tests_run++;
        if (halt !== 1'b1 || manual_en !== 1'b0 || state !== 2'b10) begin
            tests_failed++;
            $display("FAIL halt_from_run: halt=%b manual_en=%b state=%b required 1/0/10", halt, manual_en, state);
        end
        hold(B_RES, 1'b1, 8);
        hold(3'b000, 1'b0, 8);
        tests_run++;
        if (state !== 2'b00 || halt !== 1'b0 || manual_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL resume_to_run: state=%b halt=%b manual_en=%b required 00/0/0", state, halt, manual_en);
        end
    endtask

    task automatic test_simultaneous();
        hold(B_MODE, 1'b0, 8);
        hold(3'b000, 1'b0, 8);
        dut_adv_cnt = 0;
        hold(B_MODE | B_STEP, 1'b0, 8);
        hold(3'b000, 1'b0, 8);
        tests_run++;
        if (dut_adv_cnt !== 1 || state !== 2'b00) begin
            tests_failed++;
            $display("FAIL step_mode_same_cycle: pulses=%0d state=%b required 1/00", dut_adv_cnt, state);
        end
        hold(B_MODE, 1'b0, 8);
        hold(3'b000, 1'b0, 8);
        dut_adv_cnt = 0;
        hold(B_STEP, 1'b0, 7);
        tick(1'b1, B_STEP, 1'b1);
        hold(B_STEP, 1'b1, 4);
        hold(3'b000, 1'b1, 8);
        tests_run++;
        if (dut_adv_cnt !== 0 || state !== 2'b10) begin
            tests_failed++;
            $display("FAIL step_with_halt: pulses=%0d state=%b required 0/10", dut_adv_cnt, state);
        end
        hold(B_RES, 1'b1, 8);
        hold(3'b000, 1'b0, 8);
    endtask

    task automatic test_reset_mid();
        hold(B_STEP, 1'b0, 8);
        tests_run++;
        if (adv_clk !== 1'b1) begin
            tests_failed++;
            $display("FAIL pulse_before_reset: adv_clk=%b required=1", adv_clk);
        end
        tick(1'b0, B_STEP, 1'b0);
        tests_run++;
        if ({manual_en, adv_clk, halt, state} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_pulse: outputs=%b required=00000", {manual_en, adv_clk, halt, state});
        end
        hold(3'b000, 1'b0, 8);
        tick(1'b1, 3'b000, 1'b1);
        tick(1'b0, 3'b000, 1'b0);
        tests_run++;
        if ({manual_en, adv_clk, halt, state} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_in_halted: outputs=%b required=00000", {manual_en, adv_clk, halt, state});
        end
        tick(1'b0, 3'b000, 1'b1);
        tick(1'b0, 3'b000, 1'b1);
        tick(1'b1, 3'b000, 1'b1);
        tests_run++;
        if (halt !== 1'b1 || state !== 2'b10 || manual_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL hlt_through_reset: halt=%b state=%b manual_en=%b required 1/10/0", halt, state, manual_en);
        end
        hold(B_RES, 1'b0, 8);
        hold(3'b000, 1'b0, 8);
    endtask

    task automatic test_random();
        logic [2:0] b;
        logic h;
        logic r;
        b = 3'b000;
        h = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 5) == 0) b[k] = ~b[k];
            end
            if ($urandom_range(0, 39) == 0) h = ~h;
            r = ($urandom_range(0, 599) != 0);
            tick(r, b, h);
            tests_run++;
            if (state !== exp_state() || manual_en !== exp_manual() || halt !== exp_halt() || adv_clk !== m_adv) begin
                tests_failed++;
                $display("FAIL random cycle %0d: state=%b manual_en=%b halt=%b adv_clk=%b required %b/%b/%b/%b",
                         i, state, manual_en, halt, adv_clk, exp_state(), exp_manual(), exp_halt(), m_adv);
            end
        end
        tests_run++;
        if (adv_consec !== 0) begin
            tests_failed++;
            $display("FAIL adv_never_consecutive: count=%0d required=0", adv_consec);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_debounce();
        test_stepping();
        test_halt_resume();
        test_simultaneous();
        test_reset_mid();
        adv_consec = 0;
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
